// File: rtl/iir_coef_loader.sv
// Coefficient loader for the biquad-cascade IIR filter: assembles a shadow bank from a framed word stream
// and commits it to the live outputs on a sample boundary. Optional trailing checksum: IIR_COEF_CHECKSUM_EN.
module iir_coef_loader #(
   parameter int          W       = 16,
   parameter int          MAX_SEC = 3,
   parameter logic [7:0]  MAGIC   = 8'hC5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_data,
   output logic         cfg_ready,
   input  logic         sample_tick,
   output logic [W-1:0] b0,
   output logic [W-1:0] b1,
   output logic [W-1:0] b2,
   output logic [W-1:0] b3,
   output logic [W-1:0] b4,
   output logic [W-1:0] b5,
   output logic [W-1:0] b6,
   output logic [W-1:0] b7,
   output logic [W-1:0] b8,
   output logic [W-1:0] a1,
   output logic [W-1:0] a2,
   output logic [W-1:0] a3,
   output logic [W-1:0] a4,
   output logic [W-1:0] a5,
   output logic [W-1:0] a6,
   output logic [3:0]   order,
   output logic         coef_update,
   output logic         busy,
   output logic         err,
   output logic [1:0]   o_state
);

   // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
   // cfg_data is don't-care otherwise, and cfg_ready never depends on cfg_valid.

   // Slots are kept in frame order (b3k, b3k+1, b3k+2, a2k+1, a2k+2 per section); the
   // port set fixes the bank at three sections.
   localparam int NSLOT = 15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PEND = 2'd2
   } state_t;

   state_t       r_state, w_next_state;
   logic [W-1:0] r_shadow [NSLOT];
   logic [W-1:0] r_live   [NSLOT];
   logic [3:0]   r_n;
   logic [3:0]   r_order;
   logic [4:0]   r_cnt;
   logic         r_upd;
   logic         r_err;

   logic         w_accept;
   logic         w_hdr_ok;
   logic         w_last;
   logic         w_commit;
   logic         w_err;
   logic [4:0]   w_nwords;

   assign w_accept = cfg_valid && cfg_ready;
   assign w_hdr_ok = (cfg_data[W-1:W-8] == MAGIC) && (cfg_data[3:0] != 4'd0) &&
                     (cfg_data[3:0] <= 4'(MAX_SEC));
   assign w_nwords = {1'b0, r_n} * 5'd5;

`ifdef IIR_COEF_CHECKSUM_EN
   logic [W-1:0] r_sum;
   logic         w_sum_ok;
   // The checksum word arrives after all 5*N coefficients.
   assign w_last   = (r_cnt == w_nwords);
   assign w_sum_ok = (cfg_data == r_sum);
`else
   assign w_last   = (r_cnt == w_nwords - 5'd1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_commit     = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_hdr_ok) w_next_state = S_LOAD;
               else          w_err        = 1'b1;
            end
         end
         S_LOAD: begin
            // A tick coinciding with the last word is never seen here, so commit waits a tick.
            if (w_accept && w_last) begin
`ifdef IIR_COEF_CHECKSUM_EN
               if (w_sum_ok) begin
                  w_next_state = S_PEND;
               end else begin
                  w_err        = 1'b1;
                  w_next_state = S_IDLE;
               end
`else
               w_next_state = S_PEND;
`endif
            end
         end
         S_PEND: begin
            if (sample_tick) begin
               w_commit     = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSLOT; i++) begin
            r_shadow[i] <= '0;
            r_live[i]   <= '0;
         end
         r_n     <= '0;
         r_order <= '0;
         r_cnt   <= '0;
         r_upd   <= 1'b0;
         r_err   <= 1'b0;
`ifdef IIR_COEF_CHECKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         r_upd <= w_commit;
         r_err <= w_err;
         if (r_state == S_IDLE && w_accept && w_hdr_ok) begin
            r_n   <= cfg_data[3:0];
            r_cnt <= '0;
            for (int i = 0; i < NSLOT; i++) r_shadow[i] <= '0;
`ifdef IIR_COEF_CHECKSUM_EN
            r_sum <= cfg_data;
`endif
         end else if (r_state == S_LOAD && w_accept) begin
            if (r_cnt < w_nwords) r_shadow[r_cnt[3:0]] <= cfg_data;
            r_cnt <= r_cnt + 5'd1;
`ifdef IIR_COEF_CHECKSUM_EN
            r_sum <= r_sum + cfg_data;
            if (w_last && !w_sum_ok) begin
               for (int i = 0; i < NSLOT; i++) r_shadow[i] <= '0;
            end
`endif
         end
         if (w_commit) begin
            r_live  <= r_shadow;
            r_order <= r_n;
         end
      end
   end

   assign cfg_ready   = (r_state != S_PEND);
   assign busy        = (r_state != S_IDLE);
   assign coef_update = r_upd;
   assign err         = r_err;
   assign order       = r_order;
   assign o_state     = r_state;

   assign b0 = r_live[0];
   assign b1 = r_live[1];
   assign b2 = r_live[2];
   assign a1 = r_live[3];
   assign a2 = r_live[4];
   assign b3 = r_live[5];
   assign b4 = r_live[6];
   assign b5 = r_live[7];
   assign a3 = r_live[8];
   assign a4 = r_live[9];
   assign b6 = r_live[10];
   assign b7 = r_live[11];
   assign b8 = r_live[12];
   assign a5 = r_live[13];
   assign a6 = r_live[14];

endmodule

// File: tb/tb_iir_coef_loader.sv
// Bench for iir_coef_loader: directed frames, expected commit/err events queued
// by the stimulus and popped by a monitor whenever the loader pulses an output.
module tb_iir_coef_loader;

   localparam int EW = 2 + 4 + 15 * 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid;
   logic [15:0] cfg_data;
   logic        cfg_ready;
   logic        sample_tick;
   logic [15:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
   logic [15:0] a1, a2, a3, a4, a5, a6;
   logic [3:0]  order;
   logic        coef_update, busy, err;
   logic [1:0]  o_state;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];
   logic [15:0]   eb[9];
   logic [15:0]   ea[6];
   logic [3:0]    eo;
   logic [15:0]   frm[$];
   logic          sum_bad = 1'b0;

   iir_coef_loader dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .sample_tick(sample_tick),
      .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
      .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
      .order(order), .coef_update(coef_update), .busy(busy), .err(err), .o_state(o_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] act_pack();
      return {coef_update, err, order, b0, b1, b2, b3, b4, b5, b6, b7, b8, a1, a2, a3, a4, a5, a6};
   endfunction

   function automatic logic [EW-1:0] exp_pack(input logic [1:0] kind);
      logic [EW-1:0] v;
      v = '0;
      v[EW-1 -: 2] = kind;
      v[EW-3 -: 4] = eo;
      for (int i = 0; i < 9; i++) v[224 - 16 * i +: 16] = eb[i];
      for (int j = 0; j < 6; j++) v[224 - 16 * (9 + j) +: 16] = ea[j];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, expv);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset === 1'b0 && (coef_update === 1'b1 || err === 1'b1)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event act=%h exp=none", act_pack());
         end else begin
            chk("event", act_pack(), exp_q.pop_front());
         end
      end
   end

   // drivers
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] d, input logic tk);
      bit ok;
      ok          = 1'b0;
      cfg_valid   = 1'b1;
      cfg_data    = d;
      sample_tick = tk;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cfg_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      cfg_valid   = 1'b0;
      sample_tick = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout act=no_ready exp=ready word=%h", d);
      end
   endtask

   task automatic send_frame(input logic tick_last);
`ifdef IIR_COEF_CHECKSUM_EN
      logic [15:0] s;
      s = '0;
      foreach (frm[i]) s = s + frm[i];
      frm.push_back(sum_bad ? s + 16'd1 : s);
`endif
      for (int i = 0; i < frm.size(); i++)
         send_word(frm[i], tick_last && (i == frm.size() - 1));
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
   endtask

   task automatic set_zero();
      eb = '{default: 16'h0};
      ea = '{default: 16'h0};
      eo = 4'd0;
   endtask

   task automatic set_f2();
      eb = '{16'h0005, 16'h0008, 16'h0005, 16'h0800, 16'h095D, 16'h0800, 16'h0, 16'h0, 16'h0};
      ea = '{16'hF8E2, 16'h07EB, 16'h0427, 16'h07FD, 16'h0, 16'h0};
      eo = 4'd2;
   endtask

   task automatic load_f2();
      frm = '{16'hC502, 16'h0005, 16'h0008, 16'h0005, 16'hF8E2, 16'h07EB,
              16'h0800, 16'h095D, 16'h0800, 16'h0427, 16'h07FD};
   endtask

   initial begin
      logic [15:0] bad_hdr[3];
      bad_hdr = '{16'h3502, 16'hC500, 16'hC504};

      reset = 1'b1; cfg_valid = 1'b0; cfg_data = '0; sample_tick = 1'b0;
      set_zero();
      idle(3);
      reset = 1'b0;
      idle(1);
      chk("reset_outputs", act_pack(), exp_pack(2'b00));
      chk("reset_ready", EW'(cfg_ready), EW'(1'b1));
      chk("reset_busy", EW'(busy), EW'(1'b0));
      chk("reset_state", EW'(o_state), EW'(2'd0));

      // order-2 frame, commit held until the tick
      load_f2();
      send_frame(1'b0);
      idle(3);
      chk("hold_before_tick", act_pack(), exp_pack(2'b00));
      chk("pend_busy", EW'(busy), EW'(1'b1));
      chk("pend_ready", EW'(cfg_ready), EW'(1'b0));
      set_f2();
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("f2_live", act_pack(), exp_pack(2'b00));
      chk("f2_idle_busy", EW'(busy), EW'(1'b0));

      // rejected headers
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exp_pack(2'b01));
         send_word(bad_hdr[i], 1'b0);
         idle(2);
         chk("bad_hdr_idle", EW'(o_state), EW'(2'd0));
      end
      frm = '{16'hC501, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      send_frame(1'b0);
      idle(1);
      eb = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      ea = '{16'h4444, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0};
      eo = 4'd1;
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("o1_live", act_pack(), exp_pack(2'b00));

      // tick on the same edge as the last word is not used
      load_f2();
      send_frame(1'b1);
      idle(1);
      chk("tick_with_last", act_pack(), exp_pack(2'b00));
      chk("tick_with_last_state", EW'(o_state), EW'(2'd2));
      cfg_valid = 1'b1;
      cfg_data  = 16'hC501;
      idle(3);
      chk("pend_hold_ready", EW'(cfg_ready), EW'(1'b0));
      chk("pend_hold_state", EW'(o_state), EW'(2'd2));
      cfg_valid = 1'b0;
      set_f2();
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("late_commit_live", act_pack(), exp_pack(2'b00));

      // order-3 frame, then order-2 clears the upper slots
      frm = '{16'hC503,
              16'h1000, 16'h1001, 16'h1002, 16'h1A01, 16'h1A02,
              16'h2003, 16'h2004, 16'h2005, 16'h2A03, 16'h2A04,
              16'h3006, 16'h3007, 16'h3008, 16'h3A05, 16'h3A06};
      send_frame(1'b0);
      eb = '{16'h1000, 16'h1001, 16'h1002, 16'h2003, 16'h2004, 16'h2005, 16'h3006, 16'h3007, 16'h3008};
      ea = '{16'h1A01, 16'h1A02, 16'h2A03, 16'h2A04, 16'h3A05, 16'h3A06};
      eo = 4'd3;
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("o3_live", act_pack(), exp_pack(2'b00));
`ifdef IIR_COEF_CHECKSUM_EN
      load_f2();
      sum_bad = 1'b1;
      exp_q.push_back(exp_pack(2'b01));
      send_frame(1'b0);
      sum_bad = 1'b0;
      idle(2);
      chk("bad_sum_state", EW'(o_state), EW'(2'd0));
      tick();
      idle(2);
      chk("bad_sum_live", act_pack(), exp_pack(2'b00));
`endif
      load_f2();
      send_frame(1'b0);
      set_f2();
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("o3_to_o2_live", act_pack(), exp_pack(2'b00));

      // reset in the middle of LOAD
      load_f2();
      for (int i = 0; i < 4; i++) send_word(frm[i], 1'b0);
      chk("midload_busy", EW'(busy), EW'(1'b1));
      reset = 1'b1;
      #1;
      set_zero();
      chk("async_busy_drop", EW'(busy), EW'(1'b0));
      chk("async_reset_outputs", act_pack(), exp_pack(2'b00));
      chk("async_reset_ready", EW'(cfg_ready), EW'(1'b1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
      load_f2();
      send_frame(1'b0);
      set_f2();
      exp_q.push_back(exp_pack(2'b10));
      tick();
      idle(2);
      chk("post_reset_live", act_pack(), exp_pack(2'b00));

      idle(3);
      chk("queue_drained", EW'(exp_q.size()), EW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iir_coef_loader.md
Name: iir_coef_loader

Overview:
- Upstream configuration stage for the biquad-cascade IIR filter.
- Accepts a serial 16-bit word stream over a valid/ready handshake and assembles a shadow coefficient bank.
- Drives the filter's b0..b8, a1..a6 and order inputs.
- Commits the shadow bank to the live outputs atomically, only on a sample boundary, so the filter never computes a sample with a mixed coefficient set.

Parameters:
- W, 16, coefficient and config word width.
- MAX_SEC, 3, maximum number of biquad sections (3 b and 2 a coefficients each).
- MAGIC, 8'hC5, required value of header bits [15:8].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  cfg_data holds a valid word.
- cfg_data  input  W  config word.
- cfg_ready  output  1  loader can accept a word.
- sample_tick  input  1  one-cycle pulse marking the filter's sample boundary.
- b0..b8  output  W each  live feed-forward coefficients.
- a1..a6  output  W each  live feedback coefficients.
- order  output  4  live section count.
- coef_update  output  1  one-cycle pulse, cycle after commit.
- busy  output  1  frame in progress or commit pending.
- err  output  1  one-cycle pulse on rejected header or frame.

Behaviour:
- Reset (async, any state): all coefficient outputs, order, coef_update and err go to 0; busy goes to 0; cfg_ready goes to 1; state goes to IDLE; shadow bank and word counter are cleared. A frame interrupted by reset is discarded.
- Handshake: a word is accepted on a rising edge where cfg_valid and cfg_ready are both 1. cfg_data is ignored otherwise. cfg_ready=1 in IDLE and LOAD, 0 in PEND.
- Frame format:
  - Header: [15:8]=MAGIC, [3:0]=N sections, [7:4] ignored.
  - Then 5*N words, per section k=0..N-1, in order: b(3k), b(3k+1), b(3k+2), a(2k+1), a(2k+2).
- IDLE:
  - Accepted header with correct MAGIC and 1<=N<=MAX_SEC: latch N, clear the shadow bank to 0, clear the word counter, go to LOAD.
  - Any other accepted word: err pulse next cycle, stay in IDLE.
- LOAD:
  - Each accepted word is stored in the shadow slot selected by the counter; counter increments.
  - On acceptance of word 5*N, go to PEND.
  - Shadow slots beyond section N-1 stay 0.
- PEND:
  - On the first edge with sample_tick=1: live b/a outputs <= shadow and order <= N, all in the same edge. coef_update=1 for the following cycle. Go to IDLE.
- Simultaneous last-word acceptance and sample_tick: the tick is not used. Commit waits for the next tick, at least one cycle later.
- sample_tick in IDLE or LOAD: no effect; live outputs hold.
- busy=1 in LOAD and PEND.
- Live outputs change only at commit or reset.
- Stalls (cfg_valid=0) inside LOAD are unlimited; no timeout.

Optional Feature:
- IIR_COEF_CHECKSUM_EN defined:
  - Frame carries one extra trailing word: the 16-bit sum, mod 2^16, of the header and all coefficient words.
  - LOAD accepts 5*N+1 words.
  - On match, go to PEND.
  - On mismatch, err pulse, discard the shadow bank, return to IDLE with live outputs unchanged.
- Undefined: no checksum word; behaviour exactly as above.

Test Plan:
- Reset then check outputs: all b/a=0, order=0, cfg_ready=1, busy=0. Assert reset mid-LOAD: busy drops immediately (async), and a following valid frame loads cleanly.
- Send C502, 0005, 0008, 0005, F8E2, 07EB, 0800, 095D, 0800, 0427, 07FD; tick 3 cycles later. Required: b0..b5=0005, 0008, 0005, 0800, 095D, 0800; a1..a4=F8E2, 07EB, 0427, 07FD; b6..b8=a5=a6=0; order=2; coef_update pulses once; outputs unchanged before the tick.
- Headers 3502, C500, C504 -> err pulse for each, state stays IDLE, outputs unchanged, following C501 frame accepted.
- Last word and sample_tick on the same edge -> no commit on that edge; commit on the next tick. Holding cfg_valid=1 while in PEND -> cfg_ready=0, no word consumed.
- A full order=3 frame followed by the order=2 frame above -> b6..b8, a5, a6 return to 0 after the second commit.
- With IIR_COEF_CHECKSUM_EN: the order=2 frame plus EB62 -> commit. The same frame plus EB63 -> err, no commit, outputs unchanged.
